// File: rtl/scope_pkg.sv
// Shared types and constants for the triggered scope capture engine:
// FSM states, register map, trigger mode encodings and STATUS layout.
package scope_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILL_PRE = 3'd1,
        ST_ARMED    = 3'd2,
        ST_POST     = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    localparam logic [2:0] REG_LEVEL   = 3'd0;
    localparam logic [2:0] REG_CTRL    = 3'd1;
    localparam logic [2:0] REG_PRETRIG = 3'd2;
    localparam logic [2:0] REG_CMD     = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;

    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;

    localparam int CMD_ARM       = 0;
    localparam int CMD_ABORT     = 1;
    localparam int STAT_FULL     = 3;
    localparam int STAT_DISP_SEL = 4;

endpackage

// File: rtl/scope_capture_if.sv
// Avalon-MM slave register bus of the scope capture engine.
interface scope_capture_if;
    logic [15:0] writedata;
    logic        write;
    logic        read;
    logic        chipselect;
    logic [2:0]  address;
    logic [15:0] readdata;

    modport master (output writedata, write, read, chipselect, address, input readdata);
    modport slave  (input writedata, write, read, chipselect, address, output readdata);
endinterface

// File: rtl/scope_bank.sv
// Simple dual-port trace RAM: one write port, one registered read port,
// read-during-write to the same address returns the old word.
module scope_bank #(
    parameter int DEPTH = 640,
    parameter int W     = 18,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (reset) rdata_o <= '0;
        else       rdata_o <= mem[raddr_i];
    end
endmodule

// File: rtl/scope_capture.sv
// Triggered pre/post window capture into a ping-pong RAM pair; banks swap at
// frame_start so the display always reads a complete, stable trace.
module scope_capture
    import scope_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int SW      = 9,
    parameter int DEPTH   = 640,
    parameter int AW      = $clog2(DEPTH),
    parameter int AUTO_TO = 2 * DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    scope_capture_if.slave    avs,
    input  logic [NCH*SW-1:0] sample,
    input  logic              valid,
    input  logic              frame_start,
    input  logic [AW-1:0]     rd_addr,
    output logic [NCH*SW-1:0] rd_data,
    output logic              full,
    output logic              triggered
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW = $clog2(AUTO_TO + 1);
    localparam int DW = NCH * SW;
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_X = (AW + 1)'(DEPTH);

    logic [SW-1:0] level_q;
    logic          edge_q;
    logic [1:0]    mode_q;
    logic [CW-1:0] chan_q;
    logic [AW-1:0] pretrig_q;
    logic [15:0]   readdata_q, rd_mux;

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, cap_start_q, cap_start_d, disp_start_q, disp_start_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] prev_q, prev_d;
    logic          have_prev_q, have_prev_d, disp_sel_q, disp_sel_d;
    logic          full_q, full_d, trig_q, trig_d, rd_sel_q;

    logic          reg_wr, cmd_wr, capture, hit, auto_fire;
    logic [SW-1:0] cur_ch, prev_ch;
    logic [TW-1:0] cnt_inc;
    logic [AW-1:0] wr_ptr_inc, trig_start;
    logic [AW:0]   wrap_start, phys_sum;
    logic [AW-1:0] phys_addr;
    logic [DW-1:0] bank0_rd, bank1_rd;
    state_e        fill_state;

    assign reg_wr = avs.chipselect && avs.write;
    assign cmd_wr = reg_wr && (avs.address == REG_CMD);

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q   <= {1'b1, {(SW-1){1'b0}}};
            edge_q    <= 1'b1;
            mode_q    <= MODE_AUTO;
            chan_q    <= '0;
            pretrig_q <= AW'(DEPTH / 2);
        end else if (reg_wr) begin
            case (avs.address)
                REG_LEVEL: level_q <= avs.writedata[SW-1:0];
                REG_CTRL: begin
                    edge_q <= avs.writedata[0];
                    mode_q <= avs.writedata[2:1];
                    chan_q <= (int'(avs.writedata[7:3]) >= NCH) ? '0 : CW'(avs.writedata[7:3]);
                end
                REG_PRETRIG: pretrig_q <= (avs.writedata > 16'(DEPTH - 1)) ? LAST : avs.writedata[AW-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs.address)
            REG_LEVEL:   rd_mux = 16'(level_q);
            REG_CTRL:    rd_mux = {8'd0, 5'(chan_q), mode_q, edge_q};
            REG_PRETRIG: rd_mux = 16'(pretrig_q);
            REG_STATUS: begin
                rd_mux[2:0]           = state_q;
                rd_mux[STAT_FULL]     = full_q;
                rd_mux[STAT_DISP_SEL] = disp_sel_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)                            readdata_q <= '0;
        else if (avs.chipselect && avs.read)  readdata_q <= rd_mux;
    end
    assign avs.readdata = readdata_q;

    // Trigger detection on the selected channel, plus mod-DEPTH pointer helpers.
    assign cur_ch     = sample[int'(chan_q) * SW +: SW];
    assign prev_ch    = prev_q[int'(chan_q) * SW +: SW];
    assign hit        = edge_q ? (prev_ch < level_q && cur_ch >= level_q)
                               : (prev_ch > level_q && cur_ch <= level_q);
    assign cnt_inc    = cnt_q + 1'b1;
    assign auto_fire  = (mode_q == MODE_AUTO) && (int'(cnt_inc) == AUTO_TO);
    assign wr_ptr_inc = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    assign wrap_start = {1'b0, wr_ptr_q} + DEPTH_X - {1'b0, pretrig_q};
    assign trig_start = (wr_ptr_q >= pretrig_q) ? wr_ptr_q - pretrig_q : wrap_start[AW-1:0];
    assign fill_state = (pretrig_q == '0) ? ST_ARMED : ST_FILL_PRE;
    assign capture    = valid && (state_q inside {ST_FILL_PRE, ST_ARMED, ST_POST});

    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        prev_d       = prev_q;
        have_prev_d  = have_prev_q;
        cap_start_d  = cap_start_q;
        disp_start_d = disp_start_q;
        disp_sel_d   = disp_sel_q;
        full_d       = full_q;
        trig_d       = 1'b0;

        if (capture) begin
            wr_ptr_d    = wr_ptr_inc;
            prev_d      = sample;
            have_prev_d = 1'b1;
        end

        case (state_q)
            ST_FILL_PRE: if (valid) begin
                if (int'(cnt_inc) >= int'(pretrig_q)) begin
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_ARMED: if (valid) begin
                cnt_d = (int'(cnt_q) >= AUTO_TO) ? cnt_q : cnt_inc;
                if ((have_prev_q && hit) || auto_fire) begin
                    trig_d      = 1'b1;
                    cap_start_d = trig_start;
                    cnt_d       = '0;
                    if (pretrig_q == LAST) begin
                        state_d = ST_DONE;
                        full_d  = 1'b1;
                    end else begin
                        state_d = ST_POST;
                    end
                end
            end
            ST_POST: if (valid) begin
                if (int'(cnt_inc) >= DEPTH - 1 - int'(pretrig_q)) begin
                    state_d = ST_DONE;
                    full_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: if (frame_start) begin
                disp_sel_d   = !disp_sel_q;
                disp_start_d = cap_start_q;
                full_d       = 1'b0;
                wr_ptr_d     = '0;
                cnt_d        = '0;
                have_prev_d  = 1'b0;
                state_d      = (mode_q == MODE_SINGLE) ? ST_IDLE : fill_state;
            end
            default: ;
        endcase

        // Software commands override the capture sequence; abort beats arm.
        if (cmd_wr) begin
            if (avs.writedata[CMD_ABORT]) begin
                state_d = ST_IDLE;
                full_d  = 1'b0;
            end else if (avs.writedata[CMD_ARM] && state_q != ST_DONE) begin
                state_d     = fill_state;
                wr_ptr_d    = '0;
                cnt_d       = '0;
                have_prev_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_FILL_PRE;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            prev_q       <= '0;
            have_prev_q  <= 1'b0;
            cap_start_q  <= '0;
            disp_start_q <= '0;
            disp_sel_q   <= 1'b0;
            full_q       <= 1'b0;
            trig_q       <= 1'b0;
            rd_sel_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            have_prev_q  <= have_prev_d;
            cap_start_q  <= cap_start_d;
            disp_start_q <= disp_start_d;
            disp_sel_q   <= disp_sel_d;
            full_q       <= full_d;
            trig_q       <= trig_d;
            rd_sel_q     <= disp_sel_q;
        end
    end

    assign phys_sum  = {1'b0, rd_addr} + {1'b0, disp_start_q};
    assign phys_addr = (phys_sum >= DEPTH_X) ? AW'(phys_sum - DEPTH_X) : phys_sum[AW-1:0];

    scope_bank #(.DEPTH(DEPTH), .W(DW), .AW(AW)) u_bank0 (
        .clk(clk), .reset(reset), .we_i(capture && disp_sel_q), .waddr_i(wr_ptr_q),
        .wdata_i(sample), .raddr_i(phys_addr), .rdata_o(bank0_rd)
    );

    scope_bank #(.DEPTH(DEPTH), .W(DW), .AW(AW)) u_bank1 (
        .clk(clk), .reset(reset), .we_i(capture && !disp_sel_q), .waddr_i(wr_ptr_q),
        .wdata_i(sample), .raddr_i(phys_addr), .rdata_o(bank1_rd)
    );

    assign rd_data   = rd_sel_q ? bank1_rd : bank0_rd;
    assign full      = full_q;
    assign triggered = trig_q;
endmodule

// File: tb/tb_scope_capture.sv
// Scoreboard bench for scope_capture: expected trigger indices, register reads
// and display words are queued when stimulus is driven and popped on DUT output.
module tb_scope_capture;
    localparam int NCH = 2, SW = 9, DEPTH = 16, AW = 4, AUTO_TO = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH*SW-1:0] sample;
    logic              valid, frame_start;
    logic [AW-1:0]     rd_addr;
    logic [NCH*SW-1:0] rd_data;
    logic              full, triggered;

    scope_capture_if avs ();

    scope_capture #(.NCH(NCH), .SW(SW), .DEPTH(DEPTH), .AW(AW), .AUTO_TO(AUTO_TO)) dut (
        .clk(clk), .reset(reset), .avs(avs), .sample(sample), .valid(valid),
        .frame_start(frame_start), .rd_addr(rd_addr), .rd_data(rd_data),
        .full(full), .triggered(triggered)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int trig_exp[$];
    int rd_exp[$];
    int cur_idx     = -1;
    int sampled_idx = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Index of the sample the DUT accepted at the last edge; triggered refers to it.
    always @(posedge clk) sampled_idx <= valid ? cur_idx : -1;

    always @(negedge clk) begin
        if (triggered) begin
            if (trig_exp.size() == 0) check("trig_unexpected", 32'(triggered), 32'd0);
            else                      check("trig_idx", sampled_idx, trig_exp.pop_front());
        end
    end

    task automatic reg_write(input logic [2:0] addr, input logic [15:0] data);
        avs.chipselect = 1'b1;
        avs.write      = 1'b1;
        avs.address    = addr;
        avs.writedata  = data;
        tick();
        avs.chipselect = 1'b0;
        avs.write      = 1'b0;
    endtask

    task automatic reg_read(input string tag, input logic [2:0] addr, input int exp);
        avs.chipselect = 1'b1;
        avs.read       = 1'b1;
        avs.address    = addr;
        rd_exp.push_back(exp);
        tick();
        avs.chipselect = 1'b0;
        avs.read       = 1'b0;
        check(tag, 32'(avs.readdata), rd_exp.pop_front());
    endtask

    task automatic disp_read(input string tag, input int addr, input int ch, input int exp);
        rd_addr = AW'(addr);
        rd_exp.push_back(exp);
        tick();
        check(tag, 32'(rd_data[ch*SW +: SW]), rd_exp.pop_front());
    endtask

    task automatic send(input int idx, input int c0, input int c1, input logic fs = 1'b0);
        logic [SW-1:0] v0, v1;
        v0          = c0[SW-1:0];
        v1          = c1[SW-1:0];
        sample      = {v1, v0};
        valid       = 1'b1;
        frame_start = fs;
        cur_idx     = idx;
        tick();
        valid       = 1'b0;
        frame_start = 1'b0;
        cur_idx     = -1;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; valid = 1'b0; frame_start = 1'b0; sample = '0; rd_addr = '0;
        avs.chipselect = 1'b0; avs.write = 1'b0; avs.read = 1'b0;
        avs.address = '0; avs.writedata = '0;
        repeat (3) tick();
        reset = 1'b0;

        check("rst_full", 32'(full), 0);
        check("rst_trig", 32'(triggered), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_readdata", 32'(avs.readdata), 0);
        reg_read("rst_status", 3'd4, 32'h01);
        reg_read("rst_level", 3'd0, 256);
        reg_read("rst_ctrl", 3'd1, 32'h03);
        reg_read("rst_pretrig", 3'd2, 8);

        // Ramp on ch0, rising through 8, normal mode, pretrig 4.
        reg_write(3'd2, 16'd4);
        reg_write(3'd1, 16'h0001);
        reg_write(3'd0, 16'd8);
        reg_write(3'd3, 16'h0001);
        trig_exp.push_back(8);
        for (int i = 0; i < 20; i++) begin
            send(i, i, 0);
            if (i == 18) check("ramp_full_early", 32'(full), 0);
        end
        check("ramp_full", 32'(full), 1);
        frame();
        disp_read("ramp_rd0", 0, 0, 4);
        disp_read("ramp_rd4", 4, 0, 8);
        disp_read("ramp_rd15", 15, 0, 19);
        reg_read("ramp_status", 3'd4, 32'h11);

        // Ch1 falling through 100 while ch0 toggles; last POST write meets frame_start.
        reg_write(3'd1, 16'h0008);
        reg_write(3'd0, 16'd100);
        reg_write(3'd3, 16'h0001);
        trig_exp.push_back(6);
        for (int i = 0; i < 18; i++) begin
            send(i, (i % 2 == 0) ? 200 : 50, (i < 6) ? 120 : 90, i == 17);
            if (i == 16) check("fall_full_early", 32'(full), 0);
        end
        check("fall_full", 32'(full), 1);
        reg_read("coinc_status", 3'd4, 32'h1C);
        frame();
        reg_read("swap_status", 3'd4, 32'h01);
        disp_read("fall_rd4", 4, 1, 90);
        disp_read("fall_rd0", 0, 1, 120);

        // Auto mode with a flat ch0: forced trigger on the 32nd ARMED sample.
        reg_write(3'd1, 16'h0003);
        reg_write(3'd3, 16'h0001);
        trig_exp.push_back(35);
        for (int i = 0; i < 47; i++) begin
            send(i, 0, i);
            if (i == 45) check("auto_full_early", 32'(full), 0);
        end
        check("auto_full", 32'(full), 1);
        frame();
        disp_read("auto_rd4", 4, 1, 35);
        disp_read("auto_rd0", 0, 1, 31);
        disp_read("auto_rd15", 15, 1, 46);

        // Single mode: parks in IDLE after the swap, display holds under new samples.
        reg_write(3'd1, 16'h0005);
        reg_write(3'd0, 16'd8);
        reg_write(3'd3, 16'h0001);
        trig_exp.push_back(8);
        for (int i = 0; i < 20; i++) send(i, i, i + 100);
        check("single_full", 32'(full), 1);
        frame();
        reg_read("single_status", 3'd4, 32'h00);
        disp_read("single_rd4", 4, 1, 108);
        for (int i = 0; i < 10; i++) send(100 + i, 50, 50);
        disp_read("single_hold", 4, 1, 108);
        reg_read("single_idle", 3'd4, 32'h00);
        reg_write(3'd3, 16'h0001);
        reg_read("rearm_status", 3'd4, 32'h01);
        for (int i = 0; i < 4; i++) send(i, i, i + 200);
        reg_read("rearm_armed", 3'd4, 32'h02);

        // Abort in POST (arm and abort together): IDLE, full low, display unchanged.
        trig_exp.push_back(8);
        for (int i = 4; i < 11; i++) send(i, i, i + 200);
        reg_read("post_status", 3'd4, 32'h03);
        reg_write(3'd3, 16'h0003);
        reg_read("abort_status", 3'd4, 32'h00);
        check("abort_full", 32'(full), 0);
        disp_read("abort_rd4", 4, 1, 108);

        reg_write(3'd2, 16'd40);
        reg_read("pretrig_clamp", 3'd2, 15);

        repeat (3) tick();
        check("trig_pending", 32'(trig_exp.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
